// File: rtl/mc_controller_ws.sv
// Multicycle MIPS control unit: FSM main decoder, ALU decoder, memory-wait timeout,
// trap handling and a retired-instruction counter.
module mc_controller_ws #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pcen,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             zeroext,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucont,
  output logic             trap,
  output logic             timeout,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    BNEEX   = 4'd9,
    ADDIEX  = 4'd10,
    ORIEX   = 4'd11,
    IMMWB   = 4'd12,
    JEX     = 4'd13,
    TRAP    = 4'd14,
    UNUSED  = 4'd15
  } state_t;

  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BUBBLE = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Counter holds the number of un-ready cycles already spent; the trap fires
  // on the cycle that would make it reach TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, nextstate;
  logic [7:0] waitcnt;
  logic       waitstate;
  logic       timeouthit;
  logic       retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      waitcnt <= 8'd0;
      instret <= '0;
      timeout <= 1'b0;
    end else begin
      state <= nextstate;
      if (waitstate && !mem_ready && !timeouthit)
        waitcnt <= waitcnt + 8'd1;
      else
        waitcnt <= 8'd0;
      if (retire)
        instret <= instret + 1'b1;
      if (timeouthit)
        timeout <= 1'b1;
    end
  end

  always_comb begin
    nextstate  = state;
    mem_req    = 1'b0;
    pcen       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    zeroext    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucont    = ALU_ADD;
    trap       = 1'b0;
    waitstate  = 1'b0;
    timeouthit = 1'b0;
    retire     = 1'b0;

    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = 2'b01;
        waitstate = 1'b1;
        if (mem_ready) begin
          irwrite   = 1'b1;
          pcen      = 1'b1;
          nextstate = DECODE;
        end
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: nextstate = MEMADR;
          OP_RTYPE:     nextstate = RTYPEEX;
          OP_BEQ:       nextstate = BEQEX;
          OP_BNE:       nextstate = BNEEX;
          OP_ADDI:      nextstate = ADDIEX;
          OP_ORI:       nextstate = ORIEX;
          OP_J:         nextstate = JEX;
          OP_BUBBLE: begin
            nextstate = FETCH;
            retire    = 1'b1;
          end
          default:      nextstate = TRAP;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)
          nextstate = MEMRD;
        else if (op == OP_SW)
          nextstate = MEMWR;
        else
          nextstate = TRAP;
      end
      MEMRD: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        waitstate = 1'b1;
        if (mem_ready)
          nextstate = MEMWB;
      end
      MEMWB: begin
        regwrite  = 1'b1;
        memtoreg  = 1'b1;
        nextstate = FETCH;
        retire    = 1'b1;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        memwrite  = 1'b1;
        waitstate = 1'b1;
        if (mem_ready) begin
          nextstate = FETCH;
          retire    = 1'b1;
        end
      end
      RTYPEEX: begin
        alusrca   = 1'b1;
        nextstate = RTYPEWB;
        case (funct)
          FN_ADD:  alucont = ALU_ADD;
          FN_SUB:  alucont = ALU_SUB;
          FN_AND:  alucont = ALU_AND;
          FN_OR:   alucont = ALU_OR;
          FN_SLT:  alucont = ALU_SLT;
          default: nextstate = TRAP;
        endcase
      end
      RTYPEWB: begin
        regwrite  = 1'b1;
        regdst    = 1'b1;
        nextstate = FETCH;
        retire    = 1'b1;
      end
      BEQEX, BNEEX: begin
        alusrca   = 1'b1;
        alucont   = ALU_SUB;
        pcsrc     = 2'b01;
        pcen      = (state == BEQEX) ? zero : ~zero;
        nextstate = FETCH;
        retire    = 1'b1;
      end
      ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        nextstate = IMMWB;
      end
      ORIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        zeroext   = 1'b1;
        alucont   = ALU_OR;
        nextstate = IMMWB;
      end
      IMMWB: begin
        regwrite  = 1'b1;
        nextstate = FETCH;
        retire    = 1'b1;
      end
      JEX: begin
        pcsrc     = 2'b10;
        pcen      = 1'b1;
        nextstate = FETCH;
        retire    = 1'b1;
      end
      default: begin
        trap      = 1'b1;
        nextstate = TRAP;
      end
    endcase

    // A ready on the last allowed cycle wins, so only an un-ready cycle can trap.
    if (waitstate && !mem_ready && waitcnt == WAIT_LAST) begin
      timeouthit = 1'b1;
      nextstate  = TRAP;
    end

    if (reset) begin
      mem_req  = 1'b0;
      pcen     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_mc_controller_ws.sv
// Directed bench for mc_controller_ws: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_mc_controller_ws;

  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] RTYPE  = 6'b000000;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] BNE    = 6'b000101;
  localparam logic [5:0] ADDI   = 6'b001000;
  localparam logic [5:0] ORI    = 6'b001101;
  localparam logic [5:0] JMP    = 6'b000010;
  localparam logic [5:0] BUBBLE = 6'b111111;
  localparam logic [5:0] ILLOP  = 6'b010101;
  localparam logic [5:0] FSLT   = 6'b101010;
  localparam logic [5:0] FBAD   = 6'b000111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, pcen, memwrite, irwrite, regwrite;
  logic       alusrca, iord, memtoreg, regdst, zeroext;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucont;
  logic       trap, timeout;
  logic [3:0] state_o;
  logic [2:0] instret;

  typedef struct packed {
    logic [3:0] st;
    logic [4:0] strobes;
    logic [8:0] mux;
    logic [2:0] alu;
    logic [1:0] flags;
    logic [2:0] ir;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;

  mc_controller_ws #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .pcen(pcen), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca), .iord(iord),
    .memtoreg(memtoreg), .regdst(regdst), .zeroext(zeroext), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucont(alucont), .trap(trap), .timeout(timeout),
    .state_o(state_o), .instret(instret)
  );

  always #5 clk = ~clk;

  // Expected output table per state, taken straight from the state action list.
  function automatic exp_t expOut(input logic [3:0] st, input logic rst, input logic [5:0] fn,
                                  input logic z, input logic rdy, input logic [2:0] ir,
                                  input logic tr, input logic to);
    exp_t e;
    logic mr, pe, mw, iw, rw, asa, io, mtr, rd, ze;
    logic [1:0] asb, ps;
    logic [2:0] alu;
    {mr, pe, mw, iw, rw, asa, io, mtr, rd, ze} = '0;
    asb = 2'b00; ps = 2'b00; alu = 3'b010;
    case (st)
      4'd0:  begin mr = 1; asb = 2'b01; iw = rdy; pe = rdy; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mr = 1; io = 1; end
      4'd4:  begin rw = 1; mtr = 1; end
      4'd5:  begin mr = 1; io = 1; mw = 1; end
      4'd6: begin
        asa = 1;
        case (fn)
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default:   alu = 3'b010;
        endcase
      end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin asa = 1; alu = 3'b110; ps = 2'b01; pe = z; end
      4'd9:  begin asa = 1; alu = 3'b110; ps = 2'b01; pe = ~z; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: begin asa = 1; asb = 2'b10; ze = 1; alu = 3'b001; end
      4'd12: rw = 1;
      4'd13: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    if (rst) {mr, pe, mw, iw, rw} = '0;
    e.st      = st;
    e.strobes = {mr, pe, mw, iw, rw};
    e.mux     = {asa, io, mtr, rd, ze, asb, ps};
    e.alu     = alu;
    e.flags   = {tr, to};
    e.ir      = ir;
    return e;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [5:0] o, input logic [5:0] fn,
                               input logic z, input logic rdy, input logic [3:0] st,
                               input logic [2:0] ir, input logic tr, input logic to);
    @(posedge clk);
    #1;
    reset = rst; op = o; funct = fn; zero = z; mem_ready = rdy;
    sbq.push_back(expOut(st, rst, fn, z, rdy, ir, tr, to));
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      cur = sbq.pop_front();
      checkOutput("state", 16'(state_o), 16'(cur.st));
      checkOutput("strobes", 16'({mem_req, pcen, memwrite, irwrite, regwrite}), 16'(cur.strobes));
      checkOutput("muxsel", 16'({alusrca, iord, memtoreg, regdst, zeroext, alusrcb, pcsrc}), 16'(cur.mux));
      checkOutput("alucont", 16'(alucont), 16'(cur.alu));
      checkOutput("trap_timeout", 16'({trap, timeout}), 16'(cur.flags));
      checkOutput("instret", 16'(instret), 16'(cur.ir));
    end
  end

  initial begin
    reset = 1'b1; op = LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    $display("[TB] start");
    // reset held: no strobes even with mem_ready high
    applyStimulus(1, LW, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, LW, 0, 0, 1, 0, 0, 0, 0);
    // LW, memory always ready
    applyStimulus(0, LW, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, LW, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, LW, 0, 0, 1, 2, 0, 0, 0);
    applyStimulus(0, LW, 0, 0, 1, 3, 0, 0, 0);
    applyStimulus(0, LW, 0, 0, 1, 4, 0, 0, 0);
    // SW, three un-ready cycles; ready arrives exactly at the timeout boundary
    applyStimulus(0, SW, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(0, SW, 0, 0, 1, 1, 1, 0, 0);
    applyStimulus(0, SW, 0, 0, 1, 2, 1, 0, 0);
    applyStimulus(0, SW, 0, 0, 0, 5, 1, 0, 0);
    applyStimulus(0, SW, 0, 0, 0, 5, 1, 0, 0);
    applyStimulus(0, SW, 0, 0, 0, 5, 1, 0, 0);
    applyStimulus(0, SW, 0, 0, 1, 5, 1, 0, 0);
    // branches
    applyStimulus(0, BEQ, 0, 1, 1, 0, 2, 0, 0);
    applyStimulus(0, BEQ, 0, 1, 1, 1, 2, 0, 0);
    applyStimulus(0, BEQ, 0, 1, 1, 8, 2, 0, 0);
    applyStimulus(0, BNE, 0, 1, 1, 0, 3, 0, 0);
    applyStimulus(0, BNE, 0, 1, 1, 1, 3, 0, 0);
    applyStimulus(0, BNE, 0, 1, 1, 9, 3, 0, 0);
    applyStimulus(0, BNE, 0, 0, 1, 0, 4, 0, 0);
    applyStimulus(0, BNE, 0, 0, 1, 1, 4, 0, 0);
    applyStimulus(0, BNE, 0, 0, 1, 9, 4, 0, 0);
    // immediates and jump (instret wraps 7 -> 0 after J)
    applyStimulus(0, ORI, 0, 0, 1, 0, 5, 0, 0);
    applyStimulus(0, ORI, 0, 0, 1, 1, 5, 0, 0);
    applyStimulus(0, ORI, 0, 0, 1, 11, 5, 0, 0);
    applyStimulus(0, ORI, 0, 0, 1, 12, 5, 0, 0);
    applyStimulus(0, ADDI, 0, 0, 1, 0, 6, 0, 0);
    applyStimulus(0, ADDI, 0, 0, 1, 1, 6, 0, 0);
    applyStimulus(0, ADDI, 0, 0, 1, 10, 6, 0, 0);
    applyStimulus(0, ADDI, 0, 0, 1, 12, 6, 0, 0);
    applyStimulus(0, JMP, 0, 0, 1, 0, 7, 0, 0);
    applyStimulus(0, JMP, 0, 0, 1, 1, 7, 0, 0);
    applyStimulus(0, JMP, 0, 0, 1, 13, 7, 0, 0);
    // R-type SLT with two un-ready fetch cycles
    applyStimulus(0, RTYPE, FSLT, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, RTYPE, FSLT, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, RTYPE, FSLT, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, RTYPE, FSLT, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, RTYPE, FSLT, 0, 1, 6, 0, 0, 0);
    applyStimulus(0, RTYPE, FSLT, 0, 1, 7, 0, 0, 0);
    // illegal funct traps without writeback
    applyStimulus(0, RTYPE, FBAD, 0, 1, 0, 1, 0, 0);
    applyStimulus(0, RTYPE, FBAD, 0, 1, 1, 1, 0, 0);
    applyStimulus(0, RTYPE, FBAD, 0, 1, 6, 1, 0, 0);
    applyStimulus(0, RTYPE, FBAD, 0, 1, 14, 1, 1, 0);
    applyStimulus(0, RTYPE, FBAD, 0, 1, 14, 1, 1, 0);
    applyStimulus(1, LW, 0, 0, 0, 0, 0, 0, 0);
    // fetch timeout after four un-ready cycles
    for (int i = 0; i < 4; i++) applyStimulus(0, LW, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, LW, 0, 0, 1, 14, 0, 1, 1);
    applyStimulus(1, LW, 0, 0, 1, 0, 0, 0, 0);
    // reset in the middle of a read wait
    applyStimulus(0, LW, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, LW, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, LW, 0, 0, 1, 2, 0, 0, 0);
    applyStimulus(0, LW, 0, 0, 0, 3, 0, 0, 0);
    applyStimulus(0, LW, 0, 0, 0, 3, 0, 0, 0);
    applyStimulus(1, LW, 0, 0, 1, 0, 0, 0, 0);
    // nine bubbles wrap the 3-bit counter to 1
    for (int k = 0; k < 9; k++) begin
      applyStimulus(0, BUBBLE, 0, 0, 1, 0, 3'(k % 8), 0, 0);
      applyStimulus(0, BUBBLE, 0, 0, 1, 1, 3'(k % 8), 0, 0);
    end
    // illegal opcode traps without a timeout cause
    applyStimulus(0, ILLOP, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(0, ILLOP, 0, 0, 1, 1, 1, 0, 0);
    applyStimulus(0, ILLOP, 0, 0, 1, 14, 1, 1, 0);
    applyStimulus(0, ILLOP, 0, 0, 1, 14, 1, 1, 0);

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain actual=%0d expected=0 entries left", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller_ws.md
Name: mc_controller_ws

Overview:
- Next-generation multicycle MIPS control unit: FSM main decoder plus ALU decoder driving the shared-memory multicycle datapath.
- Adds a variable-latency memory handshake (mem_req/mem_ready) with a parametrised timeout.
- Adds BNE and ORI, and traps on illegal opcode or funct.
- Adds a retired-instruction counter and debug state export.

Parameters:
- TIMEOUT, 16: maximum consecutive un-ready cycles in any memory-wait state before trapping; legal range 1..255.
- CNT_W, 32: width of the retired-instruction counter instret.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op  in  6  instruction opcode field
- funct  in  6  instruction funct field
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current request this cycle
- mem_req  out  1  memory access request
- pcen  out  1  PC register enable
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register write
- regwrite  out  1  register file write
- alusrca  out  1  0: PC, 1: register A
- iord  out  1  0: PC address, 1: ALUOut address
- memtoreg  out  1  write-back source: 1 = memory data
- regdst  out  1  1 = rd, 0 = rt
- zeroext  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend
- alusrcb  out  2  00: B, 01: constant 4, 10: imm, 11: imm<<2
- pcsrc  out  2  00: ALU result, 01: ALUOut, 10: jump target
- alucont  out  3  AND=000, OR=001, ADD=010, SUB=110, SLT=111
- trap  out  1  sticky trap flag
- timeout  out  1  sticky; set when the trap cause is a memory timeout
- state_o  out  4  current state encoding
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (asynchronous, active-high):
  - state=FETCH (0), wait counter=0, instret=0, trap=0, timeout=0.
  - All outputs are a combinational function of state and inputs.
- Opcodes: LW=100011, SW=101011, RTYPE=000000, BEQ=000100, BNE=000101, ADDI=001000, ORI=001101, J=000010, BUBBLE=111111.
- Funct codes: ADD=100000, SUB=100010, AND=100100, OR=100101, SLT=101010.
- State encodings and actions (unlisted outputs are 0; alucont defaults to ADD):
  - FETCH(0): mem_req=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00. irwrite and pcen assert only while mem_ready=1. Stay in FETCH until mem_ready, then go to DECODE.
  - DECODE(1): alusrcb=11 (branch target to ALUOut). Next state by op: LW/SW→MEMADR, RTYPE→RTYPEEX, BEQ→BEQEX, BNE→BNEEX, ADDI→ADDIEX, ORI→ORIEX, J→JEX, BUBBLE→FETCH, anything else→TRAP.
  - MEMADR(2): alusrca=1, alusrcb=10. LW→MEMRD, SW→MEMWR.
  - MEMRD(3): mem_req=1, iord=1. Wait for mem_ready, then →MEMWB.
  - MEMWB(4): regwrite=1, memtoreg=1, regdst=0. →FETCH.
  - MEMWR(5): mem_req=1, iord=1, memwrite=1. memwrite is held until mem_ready, then →FETCH.
  - RTYPEEX(6): alusrca=1, alusrcb=00, alucont from funct. Unknown funct →TRAP with no writeback; otherwise →RTYPEWB.
  - RTYPEWB(7): regwrite=1, regdst=1. →FETCH.
  - BEQEX(8): alusrca=1, alucont=SUB, pcsrc=01, pcen=zero. →FETCH.
  - BNEEX(9): same as BEQEX but pcen=~zero. →FETCH.
  - ADDIEX(10): alusrca=1, alusrcb=10, alucont=ADD. →IMMWB.
  - ORIEX(11): alusrca=1, alusrcb=10, zeroext=1, alucont=OR. →IMMWB.
  - IMMWB(12): regwrite=1, regdst=0. →FETCH.
  - JEX(13): pcsrc=10, pcen=1. →FETCH.
  - TRAP(14): all strobes 0, trap=1. Stay in TRAP until reset.
- Wait counter:
  - Increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - Clears on mem_ready and on leaving the state.
  - Reaching TIMEOUT with mem_ready still 0 → TRAP with timeout=1 set. No write strobe is issued on the timeout cycle except the already-held memwrite.
  - mem_ready arriving on the same cycle as the counter hitting TIMEOUT: ready wins, no trap.
- instret:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX, BNEEX, IMMWB, JEX, or from DECODE on BUBBLE.
  - Wraps modulo 2^CNT_W. Never increments on trap.
- Unused state 15 behaves as TRAP.
- Reset asserted mid-instruction (including mid-wait) aborts immediately. No strobes are asserted while reset is high.

Test Plan:
- LW, mem_ready held 1: states 0,1,2,3,4,0 (5 cycles). regwrite=1 and memtoreg=1 only in state 4. instret 0→1.
- SW, mem_ready low for 3 cycles in MEMWR: memwrite high for 4 cycles, exit on the ready cycle. instret=1. No trap.
- BEQ zero=1 → pcen=1 in BEQEX. BNE zero=1 → pcen=0. BNE zero=0 → pcen=1. pcsrc=01 in each case.
- ORI: zeroext=1 and alucont=001 in ORIEX, then regwrite in IMMWB. RTYPE with funct=101010 gives alucont=111. RTYPE with funct=000111 → TRAP, regwrite never asserted.
- TIMEOUT=4, FETCH with mem_ready=0 forever: TRAP after 4 wait cycles, trap=1, timeout=1, held until reset. Reset returns state_o=0 with both flags cleared.
- CNT_W=3: run 9 BUBBLEs (op=111111) → instret=1 after wrap. Illegal op 010101 in DECODE → TRAP, trap=1, timeout=0.
